noc_rx_endpoint: RTL and testbench
==================================

NOC_RX_ENDPOINT -- requirements
Module: noc_rx_endpoint

Interface
REQ-001 Parameter WIDTH, default 128, flit width in bits.
REQ-002 Parameter N, default 16, number of NoC nodes; ADDRESS_WIDTH = clog2(N).
REQ-003 Parameter NUM_VC, default 2, virtual channels; VC_ADDRESS_WIDTH = clog2(NUM_VC).
REQ-004 Parameter BUF_DEPTH, default 4, flit slots per VC buffer.
REQ-005 Parameter NODE_ID, default 0, this endpoint's node address.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 i_flit_in  input  WIDTH  flit from NoC ejection port; bit WIDTH-1 valid, WIDTH-2 head, WIDTH-3 tail, VC at [WIDTH-4 -: VC_ADDRESS_WIDTH], dest at [WIDTH-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH].
REQ-009 o_credits  output  NUM_VC  per-VC credit return to NoC, one-cycle pulse per freed slot.
REQ-010 o_data  output  WIDTH  delivered flit, full format including control bits.
REQ-011 o_valid  output  1  o_data holds a deliverable flit.
REQ-012 i_ready  input  1  consumer accepts o_data when o_valid & i_ready.
REQ-013 o_vc  output  VC_ADDRESS_WIDTH  VC of the flit on o_data.
REQ-014 o_pkt_count  output  16  completed packets delivered (tail transfers), wraps 0xFFFF->0.
REQ-015 o_err  output  3  sticky flags: [0] overflow, [1] protocol, [2] misroute.

Function
REQ-016 Flit with valid=1 SHALL be written at the sampling edge into the FIFO selected by its VC field; valid=0 flits SHALL be ignored.
REQ-017 Each VC SHALL own an independent BUF_DEPTH-entry first-word-fall-through FIFO.
REQ-018 Write latency: flit sampled at edge k SHALL be visible on o_data/o_valid (if selected) in the cycle after edge k.
REQ-019 Write to a full FIFO SHALL be accepted only if the same FIFO pops in that cycle; otherwise the flit is dropped, no credit returned, o_err[0] set.
REQ-020 Arbiter states: IDLE and LOCKED(v).
REQ-021 IDLE: round-robin over VCs with non-empty FIFO, starting at rr_ptr; selected VC drives o_data/o_vc, o_valid=1.
REQ-022 IDLE, selected FIFO head flit has head=0: SHALL be popped without output (o_valid=0 that cycle), credit returned, o_err[1] set.
REQ-023 Transfer of head flit with tail=0 SHALL move IDLE->LOCKED(v); head&tail flit SHALL stay IDLE.
REQ-024 LOCKED(v): only FIFO v presented; empty FIFO v gives o_valid=0; other VCs never interleave.
REQ-025 Transfer of tail flit in LOCKED(v) SHALL return to IDLE; rr_ptr SHALL become (v+1) mod NUM_VC on every tail transfer.
REQ-026 Head flit arriving while LOCKED on same VC (missing tail) SHALL be delivered as-is and set o_err[1]; state unchanged until a tail.
REQ-027 Each transfer or discard pop SHALL pulse o_credits[v] high exactly one cycle, registered, in the cycle after the pop.
REQ-028 Head flit whose dest field != NODE_ID SHALL still be delivered and set o_err[2].
REQ-029 o_pkt_count SHALL increment by 1 on each transfer with tail=1.
REQ-030 o_valid SHALL not depend combinationally on i_ready; o_data SHALL stay stable while o_valid=1 and i_ready=0.
REQ-031 o_err bits SHALL stay set until reset.

Reset
REQ-032 reset=1 at an edge SHALL empty all FIFOs, set state IDLE, rr_ptr=0, o_credits=0, o_valid=0, o_pkt_count=0, o_err=0.
REQ-033 Reset mid-packet SHALL discard buffered flits with no credit return; flits presented during reset cycles SHALL be ignored.

Verification
REQ-034 4-flit packet VC1 dest NODE_ID, payload 999, i_ready=1 -> four flits on o_data in order, o_vc=1, o_credits=2'b10 pulses 4 times, o_pkt_count=1, o_err=0.
REQ-035 Single-flit packets on VC0 and VC1 same cycle -> VC0 delivered first then VC1, rr_ptr ends 0, o_pkt_count=2.
REQ-036 i_ready=0, BUF_DEPTH+1=5 flits to VC0 -> 5th dropped, o_err[0]=1, only 4 credits after i_ready raised.
REQ-037 Packet A VC0 (3 flits) interleaved flit-by-flit with packet B VC1 -> all A flits delivered before any B flit, o_pkt_count=2.
REQ-038 Body flit (head=0) first on VC0 -> discarded, one credit pulse on bit 0, o_err[1]=1, o_valid never high for it.
REQ-039 Head flit with dest=4, NODE_ID=0 -> delivered, o_err[2]=1; reset mid-packet -> o_valid=0, o_err=0, no credits.

Source files
------------

// File: rtl/noc_rx_endpoint.sv
// noc_rx_endpoint: NoC ejection endpoint; per-VC FWFT buffers, packet-locked round-robin delivery, credits, count, sticky errors. Ports: clk/reset, i_flit_in, o_credits, o_data/o_valid/i_ready/o_vc, o_pkt_count, o_err.
module noc_rx_endpoint #(
  parameter int WIDTH = 128,
  parameter int N = 16,
  parameter int NUM_VC = 2,
  parameter int BUF_DEPTH = 4,
  parameter int NODE_ID = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    i_flit_in,
  output logic [NUM_VC-1:0]                   o_credits,
  output logic [WIDTH-1:0]                    o_data,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [$clog2(NUM_VC)-1:0]           o_vc,
  output logic [15:0]                         o_pkt_count,
  output logic [2:0]                          o_err
);
  localparam int ADDRESS_WIDTH = $clog2(N);
  localparam int VW = $clog2(NUM_VC);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  logic [WIDTH-1:0] mem_q [NUM_VC][BUF_DEPTH];
  logic [PW-1:0] wp_q [NUM_VC], wp_d [NUM_VC], rp_q [NUM_VC], rp_d [NUM_VC];
  logic [CW-1:0] cnt_q [NUM_VC], cnt_d [NUM_VC];
  state_t state_q, state_d;
  logic [VW-1:0] lock_vc_q, lock_vc_d, rr_q, rr_d, hold_vc_q, hold_vc_d, sel, idx, wvc;
  logic hold_q, hold_d;
  logic [NUM_VC-1:0] credit_q, pop, wr;
  logic [15:0] pkt_q, pkt_d;
  logic [2:0] err_q, err_d;
  logic [WIDTH-1:0] head;
  logic avail, discard, valid, xfer, wen, drop, misroute, proto;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // Round-robin pick from rr_q; a lock or a stalled presentation pins the selection
  // so o_data cannot change under a waiting consumer.
  always_comb begin
    sel = rr_q;
    idx = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      idx = VW'((int'(rr_q) + i) % NUM_VC);
      if (cnt_q[idx] != '0) sel = idx;
    end
    sel = state_q == LOCKED ? lock_vc_q : hold_q ? hold_vc_q : sel;
    head = mem_q[sel][rp_q[sel]];
    avail = cnt_q[sel] != '0;
    discard = state_q == IDLE && avail && !head[WIDTH-2];
    valid = avail && !discard;
    xfer = valid && i_ready;
    pop = '0;
    pop[sel] = xfer || discard;
  end
  // A full buffer still accepts when it is popped in the same cycle.
  always_comb begin
    wvc = i_flit_in[WIDTH-4 -: VW];
    wen = i_flit_in[WIDTH-1] && int'(wvc) < NUM_VC;
    drop = wen && cnt_q[wvc] == CW'(BUF_DEPTH) && !pop[wvc];
    wr = '0;
    wr[wvc] = wen && !drop;
    for (int v = 0; v < NUM_VC; v++) begin
      wp_d[v] = wr[v] ? nxt(wp_q[v]) : wp_q[v];
      rp_d[v] = pop[v] ? nxt(rp_q[v]) : rp_q[v];
      cnt_d[v] = cnt_q[v] + CW'(wr[v]) - CW'(pop[v]);
    end
  end
  always_comb begin
    misroute = xfer && head[WIDTH-2] && head[WIDTH-4-VW -: ADDRESS_WIDTH] != ADDRESS_WIDTH'(NODE_ID);
    proto = discard || (state_q == LOCKED && xfer && head[WIDTH-2]);
    err_d = err_q | {misroute, proto, drop};
    hold_d = valid && !i_ready && state_q == IDLE;
    hold_vc_d = sel;
    state_d = state_q;
    lock_vc_d = lock_vc_q;
    rr_d = rr_q;
    pkt_d = pkt_q;
    if (xfer && head[WIDTH-3]) begin
      state_d = IDLE;
      rr_d = VW'((int'(sel) + 1) % NUM_VC);
      pkt_d = pkt_q + 16'd1;
    end else if (xfer && state_q == IDLE) begin
      state_d = LOCKED;
      lock_vc_d = sel;
    end
  end
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++)
      if (wr[v] && !reset) mem_q[v][wp_q[v]] <= i_flit_in;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '{default: '0};
      rp_q <= '{default: '0};
      cnt_q <= '{default: '0};
      state_q <= IDLE;
      lock_vc_q <= '0;
      rr_q <= '0;
      hold_q <= 1'b0;
      hold_vc_q <= '0;
      credit_q <= '0;
      pkt_q <= '0;
      err_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      lock_vc_q <= lock_vc_d;
      rr_q <= rr_d;
      hold_q <= hold_d;
      hold_vc_q <= hold_vc_d;
      credit_q <= pop;
      pkt_q <= pkt_d;
      err_q <= err_d;
    end
  end
  assign o_credits = credit_q;
  assign o_data = head;
  assign o_valid = valid;
  assign o_vc = sel;
  assign o_pkt_count = pkt_q;
  assign o_err = err_q;
endmodule

// File: tb/tb_noc_rx_endpoint.sv
// tb_noc_rx_endpoint: directed table plus corner-case sequences for noc_rx_endpoint.
module tb_noc_rx_endpoint;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [127:0] i_flit_in = '0;
  logic i_ready = 1'b1;
  logic [1:0] o_credits;
  logic [127:0] o_data;
  logic o_valid;
  logic o_vc;
  logic [15:0] o_pkt_count;
  logic [2:0] o_err;
  int total = 0;
  int bad = 0;
  noc_rx_endpoint dut (
    .clk(clk), .reset(reset), .i_flit_in(i_flit_in), .o_credits(o_credits),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_vc(o_vc),
    .o_pkt_count(o_pkt_count), .o_err(o_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [127:0] flit;
    logic rdy;
    logic ev;
    logic evc;
    logic [127:0] ed;
    logic [1:0] ec;
    logic [15:0] ep;
    logic [2:0] ee;
  } vec_t;
  vec_t tbl [25];
  function automatic logic [127:0] fl(input logic h, t, vc, input logic [3:0] d, input logic [31:0] p);
    return {1'b1, h, t, vc, d, 88'd0, p};
  endfunction
  function automatic vec_t rv(input logic [127:0] f, input logic r, ev, evc, input logic [127:0] ed,
                              input logic [1:0] ec, input logic [15:0] ep);
    rv = '{f, r, ev, evc, ed, ec, ep, 3'b000};
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    i_flit_in = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask
  logic [127:0] h34, b1, b2, t34, s0, s1, ah, ab, at, bh, bb, bt, mh;
  int cc, vc_cnt;
  initial begin
    h34 = fl(1, 0, 1, 0, 999); b1 = fl(0, 0, 1, 0, 1000); b2 = fl(0, 0, 1, 0, 1001); t34 = fl(0, 1, 1, 0, 1002);
    s0 = fl(1, 1, 0, 0, 22); s1 = fl(1, 1, 1, 0, 11);
    ah = fl(1, 0, 0, 0, 'hA0); ab = fl(0, 0, 0, 0, 'hA1); at = fl(0, 1, 0, 0, 'hA2);
    bh = fl(1, 0, 1, 0, 'hB0); bb = fl(0, 0, 1, 0, 'hB1); bt = fl(0, 1, 1, 0, 'hB2);
    tbl[0]  = rv(h34, 1, 0, 0, 0, 2'b00, 0);
    tbl[1]  = rv(b1, 1, 1, 1, h34, 2'b00, 0);
    tbl[2]  = rv(b2, 1, 1, 1, b1, 2'b10, 0);
    tbl[3]  = rv(t34, 1, 1, 1, b2, 2'b10, 0);
    tbl[4]  = rv(0, 1, 1, 1, t34, 2'b10, 0);
    tbl[5]  = rv(0, 1, 0, 0, 0, 2'b10, 1);
    tbl[6]  = rv(0, 1, 0, 0, 0, 2'b00, 1);
    tbl[7]  = rv(s0, 0, 0, 0, 0, 2'b00, 1);
    tbl[8]  = rv(s1, 0, 1, 0, s0, 2'b00, 1);
    tbl[9]  = rv(0, 0, 1, 0, s0, 2'b00, 1);
    tbl[10] = rv(0, 1, 1, 0, s0, 2'b00, 1);
    tbl[11] = rv(0, 1, 1, 1, s1, 2'b01, 2);
    tbl[12] = rv(0, 1, 0, 0, 0, 2'b10, 3);
    tbl[13] = rv(0, 1, 0, 0, 0, 2'b00, 3);
    tbl[14] = rv(ah, 1, 0, 0, 0, 2'b00, 3);
    tbl[15] = rv(bh, 1, 1, 0, ah, 2'b00, 3);
    tbl[16] = rv(ab, 1, 0, 0, 0, 2'b01, 3);
    tbl[17] = rv(bb, 1, 1, 0, ab, 2'b00, 3);
    tbl[18] = rv(at, 1, 0, 0, 0, 2'b01, 3);
    tbl[19] = rv(bt, 1, 1, 0, at, 2'b00, 3);
    tbl[20] = rv(0, 1, 1, 1, bh, 2'b01, 4);
    tbl[21] = rv(0, 1, 1, 1, bb, 2'b10, 4);
    tbl[22] = rv(0, 1, 1, 1, bt, 2'b10, 4);
    tbl[23] = rv(0, 1, 0, 0, 0, 2'b10, 5);
    tbl[24] = rv(0, 1, 0, 0, 0, 2'b00, 5);
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(o_valid), 0);
    chk("rst_credits", 128'(o_credits), 0);
    chk("rst_pkt", 128'(o_pkt_count), 0);
    chk("rst_err", 128'(o_err), 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      i_flit_in = tbl[i].flit;
      i_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), 128'(o_valid), 128'(tbl[i].ev));
      chk($sformatf("row%0d_credits", i), 128'(o_credits), 128'(tbl[i].ec));
      chk($sformatf("row%0d_pkt", i), 128'(o_pkt_count), 128'(tbl[i].ep));
      chk($sformatf("row%0d_err", i), 128'(o_err), 128'(tbl[i].ee));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_vc", i), 128'(o_vc), 128'(tbl[i].evc));
        chk($sformatf("row%0d_data", i), o_data, tbl[i].ed);
      end
      cyc();
    end
    // overflow: five single-flit packets into VC0 while stalled
    do_reset();
    i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      i_flit_in = fl(1, 1, 0, 0, k);
      cyc();
    end
    i_flit_in = '0;
    @(negedge clk);
    chk("ovf_err", 128'(o_err), 128'(3'b001));
    chk("ovf_stall_valid", 128'(o_valid), 1);
    chk("ovf_stall_data", o_data, fl(1, 1, 0, 0, 1));
    chk("ovf_stall_credits", 128'(o_credits), 0);
    cyc();
    i_ready = 1'b1;
    cc = 0;
    repeat (12) begin
      @(negedge clk);
      cc += int'(o_credits[0]);
    end
    chk("ovf_credit_pulses", 128'(cc), 4);
    chk("ovf_pkt", 128'(o_pkt_count), 4);
    cyc();
    // body flit with no head on VC0
    do_reset();
    i_flit_in = fl(0, 0, 0, 0, 5);
    cyc();
    i_flit_in = '0;
    cc = 0;
    vc_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cc += int'(o_credits[0]);
      vc_cnt += int'(o_valid);
    end
    chk("orphan_valid_cycles", 128'(vc_cnt), 0);
    chk("orphan_credit_pulses", 128'(cc), 1);
    chk("orphan_err", 128'(o_err), 128'(3'b010));
    cyc();
    // misrouted head, then reset in the middle of that packet
    do_reset();
    mh = fl(1, 0, 0, 4, 77);
    i_flit_in = mh;
    @(negedge clk);
    chk("mis_pre_valid", 128'(o_valid), 0);
    cyc();
    i_flit_in = '0;
    @(negedge clk);
    chk("mis_valid", 128'(o_valid), 1);
    chk("mis_data", o_data, mh);
    cyc();
    @(negedge clk);
    chk("mis_err", 128'(o_err), 128'(3'b100));
    chk("mis_credit", 128'(o_credits), 128'(2'b01));
    cyc();
    i_ready = 1'b0;
    i_flit_in = fl(0, 0, 0, 0, 78);
    cyc();
    i_flit_in = '0;
    @(negedge clk);
    chk("mid_body_valid", 128'(o_valid), 1);
    chk("mid_body_data", o_data, fl(0, 0, 0, 0, 78));
    cyc();
    reset = 1'b1;
    i_flit_in = fl(1, 1, 1, 0, 5);
    cyc();
    cyc();
    reset = 1'b0;
    i_flit_in = '0;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_valid", k), 128'(o_valid), 0);
      chk($sformatf("post_rst%0d_credits", k), 128'(o_credits), 0);
      chk($sformatf("post_rst%0d_err", k), 128'(o_err), 0);
      chk($sformatf("post_rst%0d_pkt", k), 128'(o_pkt_count), 0);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
